// File: rtl/sdrd_deser.sv
// Serial-window read deserializer: collects SDRD bits on qualified reads into
// WIDTH-bit words and hands them to the host on a valid/ready handshake.
//
//   state | meaning
//   IDLE  | no partial word, bit_cnt = 0
//   SHIFT | partial word in progress, 1 <= bit_cnt <= WIDTH-1
module sdrd_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SSER,
  input  logic                       BA13,
  input  logic                       BA12,
  input  logic                       BR_W,
  input  logic                       SDRD,
  input  logic                       out_ready,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       ovr,
  output logic                       frm_err,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH-1);
  localparam logic [IW-1:0] IDLE_MAX = '1;
  localparam logic [IW-1:0] TO_VAL   = IW'(TIMEOUT);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, word;
  logic [IW-1:0]    idle_cnt, idle_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             sample, resync, complete, timeout;

  assign sample = ~SSER & ~BA13 & BA12 &  BR_W;
  assign resync = ~SSER & ~BA13 & BA12 & ~BR_W;

  // Shift direction decides where the first bit ends up after WIDTH shifts.
  assign word = MSB_FIRST ? {sreg[WIDTH-2:0], SDRD} : {SDRD, sreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      idle_cnt <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      idle_cnt <= idle_nxt;
      bit_cnt  <= cnt_nxt;
      busy     <= (cnt_nxt != '0);
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    idle_nxt  = idle_cnt;
    cnt_nxt   = bit_cnt;
    complete  = 1'b0;
    timeout   = 1'b0;
    if (resync) begin
      state_nxt = IDLE;
      sreg_nxt  = '0;
      idle_nxt  = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (sample) begin
            state_nxt = SHIFT;
            sreg_nxt  = word;
            idle_nxt  = '0;
            cnt_nxt   = CW'(1);
          end
        end
        SHIFT: begin
          if (sample) begin
            idle_nxt = '0;
            if (bit_cnt == LAST_BIT) begin
              complete  = 1'b1;
              state_nxt = IDLE;
              sreg_nxt  = '0;
              cnt_nxt   = '0;
            end else begin
              sreg_nxt = word;
              cnt_nxt  = bit_cnt + 1'b1;
            end
          end else begin
            if (idle_cnt != IDLE_MAX) idle_nxt = idle_cnt + 1'b1;
            if ((TIMEOUT != 0) && (idle_nxt == TO_VAL)) begin
              timeout   = 1'b1;
              state_nxt = IDLE;
              sreg_nxt  = '0;
              idle_nxt  = '0;
              cnt_nxt   = '0;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          sreg_nxt  = '0;
          idle_nxt  = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  logic ovr_set;
  assign ovr_set = complete & out_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      ovr       <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      // A completing word may replace one being consumed this same cycle.
      if (complete && (!out_valid || out_ready)) begin
        out_data  <= word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovr_set)      ovr <= 1'b1;
      else if (err_clr) ovr <= 1'b0;
      if (timeout)      frm_err <= 1'b1;
      else if (err_clr) frm_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdrd_deser.sv
// Directed bench for sdrd_deser: an MSB-first and an LSB-first instance share
// one stimulus stream and are checked against hand-computed words.
module tb_sdrd_deser;

  logic       clk, rst_n;
  logic       SSER, BA13, BA12, BR_W, SDRD, out_ready, err_clr;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid, m_ovr, l_ovr, m_frm, l_frm, m_busy, l_busy;
  logic [3:0] m_cnt, l_cnt;

  int checks = 0;
  int errors = 0;

  sdrd_deser #(.WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT(64)) u_msb (
    .clk(clk), .rst_n(rst_n), .SSER(SSER), .BA13(BA13), .BA12(BA12),
    .BR_W(BR_W), .SDRD(SDRD), .out_ready(out_ready), .err_clr(err_clr),
    .out_data(m_data), .out_valid(m_valid), .ovr(m_ovr), .frm_err(m_frm),
    .busy(m_busy), .bit_cnt(m_cnt));

  sdrd_deser #(.WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT(64)) u_lsb (
    .clk(clk), .rst_n(rst_n), .SSER(SSER), .BA13(BA13), .BA12(BA12),
    .BR_W(BR_W), .SDRD(SDRD), .out_ready(out_ready), .err_clr(err_clr),
    .out_data(l_data), .out_valid(l_valid), .ovr(l_ovr), .frm_err(l_frm),
    .busy(l_busy), .bit_cnt(l_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] stream;   // stream[7] is sent first
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    SSER = 1'b1; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; SDRD = 1'bx;
  endtask

  task automatic send_bit(input logic b);
    SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b1; SDRD = b;
    step();
  endtask

  task automatic send_bits(input logic [7:0] s, input int n, input bit chk_cnt);
    for (int i = 0; i < n; i++) begin
      send_bit(s[7-i]);
      if (chk_cnt && i < 7) begin
        check("bit_cnt_m", 16'(m_cnt), 16'(i+1));
        check("busy_m", 16'(m_busy), 16'd1);
      end
    end
    bus_idle();
  endtask

  task automatic check_both(input string name, input logic [7:0] em, input logic [7:0] el,
                            input logic v);
    check({name, "_data_m"}, 16'(m_data), 16'(em));
    check({name, "_data_l"}, 16'(l_data), 16'(el));
    check({name, "_valid_m"}, 16'(m_valid), 16'(v));
    check({name, "_valid_l"}, 16'(l_valid), 16'(v));
  endtask

  initial begin
    vecs[0] = '{8'b1010_0101, 8'hA5, 8'hA5};
    vecs[1] = '{8'b1100_0000, 8'hC0, 8'h03};
    vecs[2] = '{8'b1001_0110, 8'h96, 8'h69};
    vecs[3] = '{8'b0000_0001, 8'h01, 8'h80};
    vecs[4] = '{8'b0111_0000, 8'h70, 8'h0E};

    rst_n = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    bus_idle();
    #12;
    check_both("reset", 8'h00, 8'h00, 1'b0);
    check("reset_ovr", 16'({m_ovr, l_ovr}), 16'd0);
    check("reset_frm", 16'({m_frm, l_frm}), 16'd0);
    check("reset_cnt", 16'({m_cnt, l_cnt}), 16'd0);
    check("reset_busy", 16'({m_busy, l_busy}), 16'd0);
    rst_n = 1'b1;
    step();

    // Table: one word each, out_ready held high.
    for (int v = 0; v < 5; v++) begin
      send_bits(vecs[v].stream, 8, v == 0);
      check_both($sformatf("vec%0d", v), vecs[v].exp_m, vecs[v].exp_l, 1'b1);
      check("done_busy", 16'(m_busy), 16'd0);
      check("done_cnt", 16'(l_cnt), 16'd0);
      step();
      check("vec_drop_valid", 16'({m_valid, l_valid}), 16'd0);
    end

    // Overrun: second word dropped while host stalls.
    out_ready = 1'b0;
    send_bits(8'b0011_1100, 8, 0);
    check_both("ovr_w1", 8'h3C, 8'h3C, 1'b1);
    check("ovr_none", 16'({m_ovr, l_ovr}), 16'd0);
    send_bits(8'hFF, 8, 0);
    check_both("ovr_w2", 8'h3C, 8'h3C, 1'b1);
    check("ovr_set", 16'({m_ovr, l_ovr}), 16'b11);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovr_clr", 16'({m_ovr, l_ovr}), 16'd0);
    check_both("ovr_hold", 8'h3C, 8'h3C, 1'b1);
    err_clr = 1'b1;
    send_bits(8'hFF, 8, 0);
    check("ovr_set_wins", 16'({m_ovr, l_ovr}), 16'b11);
    step();
    check("ovr_clr2", 16'({m_ovr, l_ovr}), 16'd0);
    err_clr = 1'b0;
    out_ready = 1'b1;
    step();
    check("ovr_consume", 16'({m_valid, l_valid}), 16'd0);

    // Framing timeout: 63 idle cycles tolerated, the 64th trips.
    send_bits(8'b1010_0000, 3, 0);
    for (int i = 0; i < 63; i++) step();
    check("to_63_frm", 16'({m_frm, l_frm}), 16'd0);
    check("to_63_cnt", 16'(m_cnt), 16'd3);
    step();
    check("to_64_frm", 16'({m_frm, l_frm}), 16'b11);
    check("to_64_cnt", 16'({m_cnt, l_cnt}), 16'd0);
    check("to_64_busy", 16'(m_busy), 16'd0);
    send_bits(8'h81, 8, 0);
    check_both("to_next", 8'h81, 8'h81, 1'b1);
    check("to_sticky", 16'(m_frm), 16'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_clr", 16'({m_frm, l_frm}), 16'd0);

    // Resync mid-word, with unqualified cycles that must not count.
    send_bits(8'b1111_1000, 5, 0);
    SSER = 1'b0; BA13 = 1'b1; BA12 = 1'b1; BR_W = 1'b1; SDRD = 1'b1; step();
    SSER = 1'b1; BA13 = 1'b0; step();
    SSER = 1'b0; BA12 = 1'b0; step();
    check("rs_nocount", 16'(m_cnt), 16'd5);
    SSER = 1'b0; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b0; step();
    check("rs_cnt", 16'({m_cnt, l_cnt}), 16'd0);
    send_bits(8'b0101_1010, 8, 0);
    check_both("rs_word", 8'h5A, 8'h5A, 1'b1);
    check("rs_frm", 16'({m_frm, l_frm}), 16'd0);
    step();

    // Load wins over consume on an already-valid word.
    out_ready = 1'b0;
    send_bits(8'b1010_0101, 8, 0);
    check_both("lc_w1", 8'hA5, 8'hA5, 1'b1);
    send_bits(8'b0011_1100, 7, 0);
    out_ready = 1'b1;
    send_bit(1'b0);
    bus_idle();
    check_both("lc_w2", 8'h3C, 8'h3C, 1'b1);
    check("lc_ovr", 16'({m_ovr, l_ovr}), 16'd0);
    step();
    check("lc_drop", 16'({m_valid, l_valid}), 16'd0);

    // Asynchronous reset mid-word with a pending word and overrun.
    out_ready = 1'b0;
    send_bits(8'hC3, 8, 0);
    send_bits(8'hFF, 8, 0);
    send_bits(8'hF0, 4, 0);
    check("ar_pre_cnt", 16'(m_cnt), 16'd4);
    check("ar_pre_ovr", 16'(m_ovr), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_both("ar", 8'h00, 8'h00, 1'b0);
    check("ar_cnt", 16'({m_cnt, l_cnt}), 16'd0);
    check("ar_flags", 16'({m_ovr, l_ovr, m_frm, l_frm, m_busy, l_busy}), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
